e_mdu: RTL and testbench
========================

Name: e_mdu

Overview:
- Multiply/divide unit for the E stage of the 5-stage pipeline; sits beside the E-stage ALU.
- Inputs: forwarded rs/rt operands (FWD_RD1_E / FWD_RD2_E) and a decoded MDU op.
- Owns the HI/LO registers, models multi-cycle latency with a busy counter, and returns HI/LO to the E-stage write-data mux for mfhi/mflo.
- The hazard unit stalls any D-stage MDU instruction while start or busy is high.

Parameters:
- MULT_CYCLES, 5, busy duration in cycles for mult/multu
- DIV_CYCLES, 10, busy duration in cycles for div/divu

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low; low clears all state immediately
- start  input  1  E-stage instruction is an MDU op this cycle (single-cycle pulse per instruction)
- mdu_op  input  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE)
- src_a  input  32  forwarded rs value
- src_b  input  32  forwarded rt value
- busy  output  1  multi-cycle operation in flight
- hi  output  32  architectural HI
- lo  output  32  architectural LO

Behaviour:
- Reset (reset=0, asynchronous): hi=0, lo=0, busy=0, counter=0, shadow registers=0. Takes effect mid-operation; the pending result is discarded.
- Ops are accepted only when start=1 and busy=0. start while busy=1 is a hazard-unit bug: it is ignored, and the bench flags it with an assertion.
- MTHI / MTLO: hi (resp. lo) <= src_a at the next rising edge. busy stays 0. Zero latency as seen by the following instruction.
- MULT: {hi_n, lo_n} = signed 64-bit product of src_a × src_b.
- MULTU: {hi_n, lo_n} = unsigned 64-bit product.
- DIV: lo_n = signed quotient, truncated toward zero. hi_n = remainder, carrying the sign of the dividend.
  - Overflow case 0x80000000 / 0xFFFFFFFF gives lo_n=0x80000000, hi_n=0.
- DIVU: lo_n = unsigned quotient, hi_n = unsigned remainder.
- Divide by zero (src_b=0, DIV or DIVU): the op still occupies DIV_CYCLES, and hi/lo are left unchanged at completion.
- Multi-cycle sequencing:
  - The result is computed combinationally at accept and latched into shadow regs hi_n/lo_n.
  - counter <= MULT_CYCLES or DIV_CYCLES.
  - busy <= 1 from the cycle after start.
- Each cycle while counter>0: counter decrements.
- When counter goes 1→0: busy <= 0 and hi/lo <= shadow on the same edge.
- Timing: with start at cycle T, busy is high for cycles T+1 … T+N, and the new hi/lo are visible from cycle T+N+1.
- Reads: hi/lo outputs always show committed architectural state. While busy, they still show the old values.
  - The hazard unit must stall mfhi/mflo in D while start|busy, so an old value is never consumed.
- State machine: IDLE (busy=0) → RUN on accept of MULT/MULTU/DIV/DIVU.
  - RUN → IDLE when counter reaches 0.
  - MTHI/MTLO/NONE keep IDLE.
- The counter is sized for max(MULT_CYCLES, DIV_CYCLES). MULT_CYCLES and DIV_CYCLES must both be ≥1.

Decomposition:
- Shared package/include: MDU op encodings (MDU_NONE … MDU_MTLO), default latencies.
- The decoder in the existing controller emits mdu_op and start from these constants.
- One natural sub-module: mdu_arith, a purely combinational 64-bit multiply and 32-bit divide producing hi_n/lo_n.
- e_mdu holds the counter, the shadow registers and HI/LO.

Test Plan:
- Reset release → hi=0, lo=0, busy=0. Assert reset low mid-DIV → busy=0 and hi/lo=0 immediately.
- MTHI src_a=0x12345678, next cycle MTLO src_a=0xCAFEBABE → hi=0x12345678 and lo=0xCAFEBABE one edge after each; busy never rises.
- MULT src_a=0xFFFFFFFE (-2), src_b=3 → busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - MULTU on the same operands → hi=0x00000002, lo=0xFFFFFFFA.
- DIV src_a=-7 (0xFFFFFFF9), src_b=2 → busy 10 cycles, then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
  - DIVU 7/2 → lo=3, hi=1.
- DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
  - DIVU by 0 with prior hi=5, lo=6 → busy 10 cycles, hi=5, lo=6 unchanged.
- start=1 with MULT during busy of a prior DIV → ignored; the DIV result commits on schedule; assertion fires.

Source files
------------

// File: rtl/e_mdu_pkg.sv
// ---------------------------------------------------------------------------
// e_mdu_pkg
// Shared definitions for the E-stage multiply/divide unit: the MDU op
// encodings emitted by the controller's decoder, the default latencies, the
// unit's state encoding and small op-classification helpers.
// ---------------------------------------------------------------------------
package e_mdu_pkg;

    // Encodings driven onto mdu_op by the decoder. MDU_RSVD behaves as NONE.
    typedef enum logic [2:0] {
        MDU_NONE  = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6,
        MDU_RSVD  = 3'd7
    } mdu_op_t;

    localparam int DEFAULT_MULT_CYCLES = 5;
    localparam int DEFAULT_DIV_CYCLES  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_t;

    // Ops that occupy the unit for several cycles.
    function automatic logic is_long_op(input mdu_op_t op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

    function automatic logic is_div_op(input mdu_op_t op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/e_mdu_arith.sv
// ---------------------------------------------------------------------------
// e_mdu_arith
// Purely combinational arithmetic core of the MDU. Produces the HI/LO pair
// that a MULT/MULTU/DIV/DIVU would commit.
//
// Ports:
//   op          in   3  MDU op (e_mdu_pkg::mdu_op_t encoding)
//   src_a       in  32  rs operand (multiplicand / dividend)
//   src_b       in  32  rt operand (multiplier / divisor)
//   hi_n        out 32  product high word / remainder
//   lo_n        out 32  product low word  / quotient
//   div_by_zero out  1  src_b is zero (result must not be committed for divides)
// ---------------------------------------------------------------------------
module e_mdu_arith
    import e_mdu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic [31:0] hi_n,
    output logic [31:0] lo_n,
    output logic        div_by_zero
);

    mdu_op_t            op_dec;
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic               div_signed;
    logic               a_neg;
    logic               b_neg;
    logic        [31:0] a_mag;
    logic        [31:0] b_mag;
    logic        [31:0] q_mag;
    logic        [31:0] r_mag;
    logic        [31:0] quot;
    logic        [31:0] rem;

    assign op_dec      = mdu_op_t'(op);
    assign div_by_zero = (src_b == 32'd0);

    // Full-width products; operands are extended explicitly so the multiply
    // is carried out at 64 bits in both flavours.
    assign prod_s = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});
    assign prod_u = {32'd0, src_a} * {32'd0, src_b};

    // Signed divide is done on magnitudes, then the signs are restored:
    // quotient negative when operand signs differ, remainder follows the
    // dividend. The 0x80000000 / -1 overflow falls out naturally: the
    // magnitude 0x80000000 divided by 1 negates back to 0x80000000, rem 0.
    always_comb begin
        div_signed = (op_dec == MDU_DIV);
        a_neg      = div_signed & src_a[31];
        b_neg      = div_signed & src_b[31];
        a_mag      = a_neg ? (~src_a + 32'd1) : src_a;
        b_mag      = b_neg ? (~src_b + 32'd1) : src_b;
        q_mag      = 32'd0;
        r_mag      = 32'd0;
        if (b_mag != 32'd0) begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
        end
        quot = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        rem  = a_neg ? (~r_mag + 32'd1) : r_mag;
    end

    always_comb begin
        hi_n = 32'd0;
        lo_n = 32'd0;
        case (op_dec)
            MDU_MULT:  {hi_n, lo_n} = prod_s;
            MDU_MULTU: {hi_n, lo_n} = prod_u;
            MDU_DIV,
            MDU_DIVU: begin
                hi_n = rem;
                lo_n = quot;
            end
            default: begin
                hi_n = 32'd0;
                lo_n = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/e_mdu.sv
// ---------------------------------------------------------------------------
// e_mdu
// E-stage multiply/divide unit. Owns architectural HI/LO, computes the
// result of a long op at accept time into shadow registers and commits it
// after a fixed latency, modelled by a down-counter. MTHI/MTLO write
// HI/LO directly on the next edge.
//
// Ports:
//   clk     in   1  clock, all state on rising edge
//   reset   in   1  asynchronous active-low reset
//   start   in   1  E-stage instruction is an MDU op (one-cycle pulse)
//   mdu_op  in   3  op encoding (e_mdu_pkg::mdu_op_t)
//   src_a   in  32  forwarded rs value
//   src_b   in  32  forwarded rt value
//   busy    out  1  multi-cycle op in flight
//   hi      out 32  architectural HI
//   lo      out 32  architectural LO
//
// MULT_CYCLES and DIV_CYCLES must both be at least 1.
// ---------------------------------------------------------------------------
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int MULT_CYCLES = DEFAULT_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEFAULT_DIV_CYCLES
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdu_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    mdu_op_t     op_dec;
    mdu_state_t  state_reg;
    mdu_state_t  state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;
    logic [31:0] hi_shadow_reg;
    logic [31:0] lo_shadow_reg;
    logic        commit_en_reg;   // cleared for divide-by-zero: HI/LO keep old values

    logic        accept;
    logic        accept_long;
    logic        busy_comb;
    logic        finish_comb;
    logic [31:0] hi_n;
    logic [31:0] lo_n;
    logic        div_by_zero;

    assign op_dec = mdu_op_t'(mdu_op);

    // A start while busy is a hazard-unit error and is simply dropped.
    assign accept      = start && (state_reg == ST_IDLE);
    assign accept_long = accept && is_long_op(op_dec);

    e_mdu_arith u_arith (
        .op          (mdu_op),
        .src_a       (src_a),
        .src_b       (src_b),
        .hi_n        (hi_n),
        .lo_n        (lo_n),
        .div_by_zero (div_by_zero)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (accept_long) state_next = ST_RUN;
            // <= 1 rather than == 1 so a corrupted zero count cannot wedge RUN.
            ST_RUN:  if (cnt_reg <= CNT_W'(1)) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy_comb   = 1'b0;
        finish_comb = 1'b0;
        case (state_reg)
            ST_RUN: begin
                busy_comb   = 1'b1;
                finish_comb = (cnt_reg <= CNT_W'(1));
            end
            default: begin
                busy_comb   = 1'b0;
                finish_comb = 1'b0;
            end
        endcase
    end

    // ---------------- latency counter and shadow result ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg       <= '0;
            hi_shadow_reg <= 32'd0;
            lo_shadow_reg <= 32'd0;
            commit_en_reg <= 1'b0;
        end else if (accept_long) begin
            cnt_reg       <= is_div_op(op_dec) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            hi_shadow_reg <= hi_n;
            lo_shadow_reg <= lo_n;
            commit_en_reg <= !(is_div_op(op_dec) && div_by_zero);
        end else if ((state_reg == ST_RUN) && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - CNT_W'(1);
        end
    end

    // ---------------- architectural HI/LO ----------------
    // Commit and MTHI/MTLO cannot coincide: moves are only accepted in IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_reg <= 32'd0;
            lo_reg <= 32'd0;
        end else if (finish_comb) begin
            if (commit_en_reg) begin
                hi_reg <= hi_shadow_reg;
                lo_reg <= lo_shadow_reg;
            end
        end else if (accept) begin
            if (op_dec == MDU_MTHI) hi_reg <= src_a;
            if (op_dec == MDU_MTLO) lo_reg <= src_a;
        end
    end

    assign busy = busy_comb;
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule

// File: tb/tb_e_mdu.sv
// ---------------------------------------------------------------------------
// tb_e_mdu
// Self-checking bench for e_mdu. Inputs are driven on the falling edge,
// outputs are sampled on the falling edge. Expected HI/LO come from a
// behavioural model using 64-bit integer arithmetic.
// ---------------------------------------------------------------------------
module tb_e_mdu;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  mdu_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks;
    int errors;
    int hazard_cnt;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    e_mdu dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .mdu_op (mdu_op),
        .src_a  (src_a),
        .src_b  (src_b),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hazard monitor: a start presented while the unit is busy.
    always @(posedge clk) begin
        if (reset && start && busy) begin
            hazard_cnt <= hazard_cnt + 1;
            $display("hazard: start asserted while busy (op=%0d) at %0t", mdu_op, $time);
        end
    end

    // ---------------- reference model ----------------
    function automatic int ref_latency(input int op);
        if (op == 1 || op == 2) return MULT_LAT;
        if (op == 3 || op == 4) return DIV_LAT;
        return 0;
    endfunction

    function automatic void ref_op(input int op, input logic [31:0] a, input logic [31:0] b,
                                   inout logic [31:0] h, inout logic [31:0] l);
        longint          sa, sb, q, r, p;
        longint unsigned pu;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            1: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
            2: begin pu = longint'({32'd0, a}) * longint'({32'd0, b}); h = pu[63:32]; l = pu[31:0]; end
            3: if (b != 0) begin q = sa / sb; r = sa % sb; l = q[31:0]; h = r[31:0]; end
            4: if (b != 0) begin l = a / b; h = a % b; end
            5: h = a;
            6: l = a;
            default: ;
        endcase
    endfunction

    // ---------------- stimulus helpers (no checks inside) ----------------
    task automatic issue(input int op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start  = 1'b1;
        mdu_op = 3'(op);
        src_a  = a;
        src_b  = b;
        @(negedge clk);
        start  = 1'b0;
        mdu_op = 3'd0;
    endtask

    // Counts busy cycles from the falling edge after start; bounded.
    task automatic count_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (n >= 100) n = 999;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0; start = 1'b0; mdu_op = 3'd0; src_a = 32'd0; src_b = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            errors++;
            $display("FAIL reset_release: busy=%b hi=%h lo=%h, required busy=0 hi=0 lo=0", busy, hi, lo);
        end else $display("reset_release: busy=0 hi=0 lo=0 ok");
        exp_hi = 32'd0; exp_lo = 32'd0;
    endtask

    task automatic test_moves();
        int busy_seen;
        busy_seen = 0;
        @(negedge clk);
        start = 1'b1; mdu_op = 3'd5; src_a = 32'h12345678; src_b = 32'h0;
        @(negedge clk);
        if (busy !== 1'b0) busy_seen++;
        checks++;
        if (hi !== 32'h12345678) begin
            errors++;
            $display("FAIL mthi: hi=%h required 12345678", hi);
        end else $display("mthi: hi=%h ok", hi);
        mdu_op = 3'd6; src_a = 32'hCAFEBABE;
        @(negedge clk);
        start = 1'b0; mdu_op = 3'd0;
        if (busy !== 1'b0) busy_seen++;
        checks++;
        if (lo !== 32'hCAFEBABE || hi !== 32'h12345678) begin
            errors++;
            $display("FAIL mtlo: hi=%h lo=%h required hi=12345678 lo=cafebabe", hi, lo);
        end else $display("mtlo: lo=%h ok", lo);
        @(negedge clk);
        if (busy !== 1'b0) busy_seen++;
        checks++;
        if (busy_seen != 0) begin
            errors++;
            $display("FAIL move_busy: busy high %0d samples, required 0", busy_seen);
        end else $display("move_busy: busy stayed low ok");
        exp_hi = 32'h12345678; exp_lo = 32'hCAFEBABE;
    endtask

    // One long op with latency and result checks; used by directed cases.
    task automatic run_long(input string name, input int op, input logic [31:0] a, input logic [31:0] b);
        int n;
        logic [31:0] old_hi, old_lo;
        old_hi = hi; old_lo = lo;
        ref_op(op, a, b, exp_hi, exp_lo);
        issue(op, a, b);
        checks++;
        if (hi !== old_hi || lo !== old_lo) begin
            errors++;
            $display("FAIL %s_hold: hi=%h lo=%h while busy, required old hi=%h lo=%h", name, hi, lo, old_hi, old_lo);
        end
        count_busy(n);
        checks++;
        if (n != ref_latency(op)) begin
            errors++;
            $display("FAIL %s_latency: busy %0d cycles, required %0d", name, n, ref_latency(op));
        end
        checks++;
        if (hi !== exp_hi || lo !== exp_lo) begin
            errors++;
            $display("FAIL %s_result: hi=%h lo=%h, required hi=%h lo=%h", name, hi, lo, exp_hi, exp_lo);
        end else $display("%s: a=%h b=%h busy=%0d hi=%h lo=%h ok", name, a, b, n, hi, lo);
    endtask

    task automatic test_mult();
        run_long("mult", 1, 32'hFFFFFFFE, 32'd3);
        run_long("multu", 2, 32'hFFFFFFFE, 32'd3);
    endtask

    task automatic test_div();
        run_long("div", 3, 32'hFFFFFFF9, 32'd2);
        run_long("divu", 4, 32'd7, 32'd2);
        run_long("div_ovf", 3, 32'h80000000, 32'hFFFFFFFF);
        issue(5, 32'd5, 32'd0);
        issue(6, 32'd6, 32'd0);
        exp_hi = 32'd5; exp_lo = 32'd6;
        run_long("divu_zero", 4, 32'd1234, 32'd0);
        checks++;
        if (hi !== 32'd5 || lo !== 32'd6) begin
            errors++;
            $display("FAIL divu_zero_keep: hi=%h lo=%h, required hi=5 lo=6", hi, lo);
        end
        run_long("div_zero", 3, 32'hDEAD0000, 32'd0);
    endtask

    task automatic test_back_to_back();
        int n, h0;
        h0 = hazard_cnt;
        ref_op(3, 32'd100, 32'd7, exp_hi, exp_lo);
        issue(3, 32'd100, 32'd7);
        repeat (2) @(negedge clk);
        start = 1'b1; mdu_op = 3'd1; src_a = 32'd9; src_b = 32'd9;
        @(negedge clk);
        start = 1'b0; mdu_op = 3'd0;
        count_busy(n);
        checks++;
        if (n + 3 != DIV_LAT) begin
            errors++;
            $display("FAIL hazard_latency: busy %0d cycles, required %0d", n + 3, DIV_LAT);
        end
        checks++;
        if (hi !== exp_hi || lo !== exp_lo) begin
            errors++;
            $display("FAIL hazard_result: hi=%h lo=%h, required hi=%h lo=%h", hi, lo, exp_hi, exp_lo);
        end else $display("hazard_ignore: div result hi=%h lo=%h ok", hi, lo);
        checks++;
        if (hazard_cnt != h0 + 1) begin
            errors++;
            $display("FAIL hazard_flag: %0d events, required 1", hazard_cnt - h0);
        end
    endtask

    task automatic test_random();
        int op, n;
        logic [31:0] a, b;
        for (int i = 0; i < 40; i++) begin
            op = int'($urandom_range(0, 7));
            a  = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                default: b = $urandom;
            endcase
            ref_op(op, a, b, exp_hi, exp_lo);
            issue(op, a, b);
            count_busy(n);
            checks++;
            if (n != ref_latency(op) || hi !== exp_hi || lo !== exp_lo) begin
                errors++;
                $display("FAIL rand_%0d: op=%0d a=%h b=%h busy=%0d hi=%h lo=%h, required busy=%0d hi=%h lo=%h",
                         i, op, a, b, n, hi, lo, ref_latency(op), exp_hi, exp_lo);
            end else $display("rand_%0d: op=%0d a=%h b=%h hi=%h lo=%h ok", i, op, a, b, hi, lo);
        end
    endtask

    task automatic test_reset_mid_div();
        issue(5, 32'hA5A5A5A5, 32'd0);
        issue(6, 32'h5A5A5A5A, 32'd0);
        issue(3, 32'd1000, 32'd3);
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_div: busy=%b hi=%h lo=%h, required busy=0 hi=0 lo=0", busy, hi, lo);
        end else $display("reset_mid_div: cleared immediately ok");
        @(negedge clk);
        reset = 1'b1;
        repeat (DIV_LAT + 2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            errors++;
            $display("FAIL reset_discard: busy=%b hi=%h lo=%h, required busy=0 hi=0 lo=0", busy, hi, lo);
        end else $display("reset_discard: pending result dropped ok");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        hazard_cnt = 0;
        test_reset();
        test_moves();
        test_mult();
        test_div();
        test_back_to_back();
        test_random();
        test_reset_mid_div();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time limit so the bench cannot hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
